// File: rtl/mac_frame_accumulator_if.sv
// Stream bundle between the MAC result pipeline, the frame accumulator and its frame consumer.
// slave is the accumulator side; master is the upstream/downstream environment side.
interface mac_frame_accumulator_if #(
  parameter int DW = 8,
  parameter int AW = 2*DW+4
);
  logic [2*DW-1:0] s_data;
  logic            s_valid;
  logic            s_ready;
  logic            s_ovf;
  logic            flush;
  logic [AW-1:0]   m_data;
  logic [7:0]      m_count;
  logic            m_ovf;
  logic            m_sat;
  logic            m_valid;
  logic            m_ready;

  modport slave (
    input  s_data, s_valid, s_ovf, flush, m_ready,
    output s_ready, m_data, m_count, m_ovf, m_sat, m_valid
  );

  modport master (
    output s_data, s_valid, s_ovf, flush, m_ready,
    input  s_ready, m_data, m_count, m_ovf, m_sat, m_valid
  );
endinterface

// File: rtl/mac_frame_accumulator.sv
// Sums N MAC results (saturating) into one frame total; m_valid rises the cycle after the closing beat.
// Input is stalled (s_ready=0) while a frame result waits for m_ready; s_ready never depends on m_ready.
module mac_frame_accumulator #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int AW = 2*DW+4
) (
  input logic                    clk,
  input logic                    reset,
  mac_frame_accumulator_if.slave bus
);
  typedef enum logic {ACC, OUT} state_t;

  localparam logic [7:0] N_CNT = 8'(N);

  state_t        state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic          ovf, ovf_nxt;
  logic          sat, sat_nxt;

  logic [AW-1:0] m_data_q, m_data_nxt;
  logic [7:0]    m_count_q, m_count_nxt;
  logic          m_ovf_q, m_ovf_nxt;
  logic          m_sat_q, m_sat_nxt;

  logic          beat;
  logic [AW:0]   sum;
  logic [AW-1:0] acc_add;
  logic [7:0]    cnt_add;
  logic          ovf_add;
  logic          sat_add;

  assign bus.s_ready = reset && (state == ACC);
  assign bus.m_valid = (state == OUT);
  assign bus.m_data  = m_data_q;
  assign bus.m_count = m_count_q;
  assign bus.m_ovf   = m_ovf_q;
  assign bus.m_sat   = m_sat_q;

  assign beat = bus.s_valid && bus.s_ready;

  // One extra bit catches the carry that signals saturation.
  assign sum     = (AW+1)'(acc) + (AW+1)'(bus.s_data);
  assign acc_add = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
  assign sat_add = sat | sum[AW];
  assign cnt_add = cnt + 8'd1;
  assign ovf_add = ovf | bus.s_ovf;

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf;
    sat_nxt     = sat;
    m_data_nxt  = m_data_q;
    m_count_nxt = m_count_q;
    m_ovf_nxt   = m_ovf_q;
    m_sat_nxt   = m_sat_q;
    case (state)
      ACC: begin
        if (beat) begin
          acc_nxt = acc_add;
          cnt_nxt = cnt_add;
          ovf_nxt = ovf_add;
          sat_nxt = sat_add;
          if (cnt_add == N_CNT || bus.flush) begin
            state_nxt   = OUT;
            m_data_nxt  = acc_add;
            m_count_nxt = cnt_add;
            m_ovf_nxt   = ovf_add;
            m_sat_nxt   = sat_add;
          end
        end else if (bus.flush && cnt != 8'd0) begin
          // Flush on an empty frame is dropped so no zero-beat result is emitted.
          state_nxt   = OUT;
          m_data_nxt  = acc;
          m_count_nxt = cnt;
          m_ovf_nxt   = ovf;
          m_sat_nxt   = sat;
        end
      end
      OUT: begin
        if (bus.m_ready) begin
          state_nxt = ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          sat_nxt   = 1'b0;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      sat       <= 1'b0;
      m_data_q  <= '0;
      m_count_q <= '0;
      m_ovf_q   <= 1'b0;
      m_sat_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      ovf       <= ovf_nxt;
      sat       <= sat_nxt;
      m_data_q  <= m_data_nxt;
      m_count_q <= m_count_nxt;
      m_ovf_q   <= m_ovf_nxt;
      m_sat_q   <= m_sat_nxt;
    end
  end
endmodule
